apb_arbiter: RTL and testbench

Two-master APB arbiter sharing one APB slave bus: the `ahb_to_apb` bridge output and a second APB requester, such as a boot-config engine or debug port. It sits between the requesters and the APB slave decoder. It serialises transfers, re-issues the granted request as a full setup/access sequence on the slave side, and returns PREADY/PRDATA/PSLVERR only to the granted master. It runs on HCLK with the bridge's PCLKEN qualifier.

---
 rtl/apb_arb_pkg.sv | 12 +
 rtl/apb_arb_pick.sv | 42 ++++
 rtl/apb_arbiter.sv | 150 +++++++++++++++
 tb/tb_apb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-master APB arbiter.
package apb_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

endpackage

// File: rtl/apb_arb_pick.sv
// Combinational grant selection for the APB arbiter.
// APB_ARB_RR_EN selects round-robin tie-breaking; otherwise master 0 wins ties.
module apb_arb_pick
  import apb_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   last_grant,
  input  logic                   cur_grant,
  input  logic                   mask_cur,
  output logic                   valid,
  output logic                   grant
);

  logic [NUM_MASTERS-1:0] req_eff_s;
  logic                   tie_grant_s;

`ifdef APB_ARB_RR_EN
  assign tie_grant_s = ~last_grant;
`else
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
  assign tie_grant_s         = 1'b0;
`endif

  // Drop the completing master's stale request, then choose among the rest.
  always_comb begin
    req_eff_s = req;
    if (mask_cur) begin
      req_eff_s[cur_grant] = 1'b0;
    end else begin
      req_eff_s = req;
    end
    valid = |req_eff_s;
    case (req_eff_s)
      2'b11:   grant = tie_grant_s;
      2'b10:   grant = 1'b1;
      2'b01:   grant = 1'b0;
      default: grant = cur_grant;
    endcase
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-master APB arbiter: serialises requests onto one APB slave bus.
// Build option: define APB_ARB_RR_EN for round-robin ties (default fixed priority).
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDRWIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 PCLKEN,
  input  logic                 M0_PSEL,
  input  logic                 M0_PENABLE,
  input  logic                 M0_PWRITE,
  input  logic [ADDRWIDTH-1:0] M0_PADDR,
  input  logic [31:0]          M0_PWDATA,
  input  logic [3:0]           M0_PSTRB,
  input  logic [2:0]           M0_PPROT,
  output logic [31:0]          M0_PRDATA,
  output logic                 M0_PREADY,
  output logic                 M0_PSLVERR,
  input  logic                 M1_PSEL,
  input  logic                 M1_PENABLE,
  input  logic                 M1_PWRITE,
  input  logic [ADDRWIDTH-1:0] M1_PADDR,
  input  logic [31:0]          M1_PWDATA,
  input  logic [3:0]           M1_PSTRB,
  input  logic [2:0]           M1_PPROT,
  output logic [31:0]          M1_PRDATA,
  output logic                 M1_PREADY,
  output logic                 M1_PSLVERR,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [31:0]          PWDATA,
  output logic [3:0]           PSTRB,
  output logic [2:0]           PPROT,
  input  logic [31:0]          PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR,
  output logic                 APBACTIVE
);

  state_t state_r, state_nxt_s;
  logic   grant_r, grant_nxt_s;
  logic   last_grant_r, last_grant_nxt_s;
  logic   done_s, pick_valid_s, pick_grant_s, psel_s;
  logic   unused_penable_s;

  assign unused_penable_s = M0_PENABLE | M1_PENABLE;
  assign done_s = (state_r == ST_ACCESS) & PREADY & PCLKEN;
  assign psel_s = (state_r == ST_SETUP) | (state_r == ST_ACCESS);

  apb_arb_pick u_pick (
    .req        ({M1_PSEL, M0_PSEL}),
    .last_grant (last_grant_r),
    .cur_grant  (grant_r),
    .mask_cur   (done_s),
    .valid      (pick_valid_s),
    .grant      (pick_grant_s)
  );

  // State, grant and last-grant registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Next-state logic; a completion hands straight over to a waiting master.
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    last_grant_nxt_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (PCLKEN && pick_valid_s) begin
          state_nxt_s = ST_SETUP;
          grant_nxt_s = pick_grant_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (PCLKEN) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_SETUP;
        end
      end
      ST_ACCESS: begin
        if (done_s) begin
          last_grant_nxt_s = grant_r;
          if (pick_valid_s) begin
            state_nxt_s = ST_SETUP;
            grant_nxt_s = pick_grant_s;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Slave-side request mux, zeroed outside a transfer.
  always_comb begin
    PSEL    = psel_s;
    PENABLE = (state_r == ST_ACCESS);
    PWRITE  = 1'b0;
    PADDR   = {ADDRWIDTH{1'b0}};
    PWDATA  = 32'h0000_0000;
    PSTRB   = 4'h0;
    PPROT   = 3'b000;
    if (psel_s) begin
      if (grant_r) begin
        PWRITE = M1_PWRITE;
        PADDR  = M1_PADDR;
        PWDATA = M1_PWDATA;
        PSTRB  = M1_PSTRB;
        PPROT  = M1_PPROT;
      end else begin
        PWRITE = M0_PWRITE;
        PADDR  = M0_PADDR;
        PWDATA = M0_PWDATA;
        PSTRB  = M0_PSTRB;
        PPROT  = M0_PPROT;
      end
    end else begin
      PWRITE = 1'b0;
    end
  end

  assign M0_PREADY  = done_s & ~grant_r;
  assign M1_PREADY  = done_s & grant_r;
  assign M0_PSLVERR = M0_PREADY & PSLVERR;
  assign M1_PSLVERR = M1_PREADY & PSLVERR;
  assign M0_PRDATA  = M0_PREADY ? PRDATA : 32'h0000_0000;
  assign M1_PRDATA  = M1_PREADY ? PRDATA : 32'h0000_0000;
  assign APBACTIVE  = M0_PSEL | M1_PSEL | (state_r != ST_IDLE);

endmodule

// File: tb/tb_apb_arbiter.sv
// Randomised bench for apb_arbiter checked cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_apb_arbiter;
  localparam int AW = 16;

  logic HCLK = 1'b0;
  logic HRESET, PCLKEN;
  logic M0_PSEL, M0_PENABLE, M0_PWRITE, M1_PSEL, M1_PENABLE, M1_PWRITE;
  logic [AW-1:0] M0_PADDR, M1_PADDR, PADDR;
  logic [31:0] M0_PWDATA, M1_PWDATA, M0_PRDATA, M1_PRDATA, PWDATA, PRDATA;
  logic [3:0] M0_PSTRB, M1_PSTRB, PSTRB;
  logic [2:0] M0_PPROT, M1_PPROT, PPROT;
  logic M0_PREADY, M0_PSLVERR, M1_PREADY, M1_PSLVERR;
  logic PSEL, PENABLE, PWRITE, PREADY, PSLVERR, APBACTIVE;

  apb_arbiter #(.ADDRWIDTH(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PCLKEN(PCLKEN),
    .M0_PSEL(M0_PSEL), .M0_PENABLE(M0_PENABLE), .M0_PWRITE(M0_PWRITE), .M0_PADDR(M0_PADDR),
    .M0_PWDATA(M0_PWDATA), .M0_PSTRB(M0_PSTRB), .M0_PPROT(M0_PPROT), .M0_PRDATA(M0_PRDATA),
    .M0_PREADY(M0_PREADY), .M0_PSLVERR(M0_PSLVERR),
    .M1_PSEL(M1_PSEL), .M1_PENABLE(M1_PENABLE), .M1_PWRITE(M1_PWRITE), .M1_PADDR(M1_PADDR),
    .M1_PWDATA(M1_PWDATA), .M1_PSTRB(M1_PSTRB), .M1_PPROT(M1_PPROT), .M1_PRDATA(M1_PRDATA),
    .M1_PREADY(M1_PREADY), .M1_PSLVERR(M1_PSLVERR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .APBACTIVE(APBACTIVE)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bench-side masters: one pending transaction each.
  bit          act [2];
  int          age [2];
  bit          wr [2];
  logic [AW-1:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  strb [2];
  logic [2:0]  prot [2];

  // Reference model: owner of the bus (-1 = free), whether its access phase is reached.
  int owner = -1;
  bit in_acc = 1'b0;
  int last = 1;

  function automatic int choose(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef APB_ARB_RR_EN
      return 1 - last;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  task automatic model_reset();
    owner = -1; in_acc = 1'b0; last = 1;
  endtask

  task automatic model_step();
    bit r [2];
    r[0] = M0_PSEL; r[1] = M1_PSEL;
    if (HRESET) model_reset();
    else if (PCLKEN) begin
      if (owner < 0) begin
        if (r[0] || r[1]) begin owner = choose(r[0], r[1]); in_acc = 1'b0; end
      end else if (!in_acc) in_acc = 1'b1;
      else if (PREADY) begin
        last = owner;
        if (r[1-owner]) begin owner = 1 - owner; in_acc = 1'b0; end
        else begin owner = -1; in_acc = 1'b0; end
      end
    end
  endtask

  task automatic drive_masters();
    M0_PSEL = act[0]; M0_PENABLE = act[0] && age[0] > 0; M0_PWRITE = wr[0];
    M0_PADDR = addr[0]; M0_PWDATA = wdata[0]; M0_PSTRB = strb[0]; M0_PPROT = prot[0];
    M1_PSEL = act[1]; M1_PENABLE = act[1] && age[1] > 0; M1_PWRITE = wr[1];
    M1_PADDR = addr[1]; M1_PWDATA = wdata[1]; M1_PSTRB = strb[1]; M1_PPROT = prot[1];
  endtask

  task automatic new_txn(input int m);
    act[m] = 1'b1; age[m] = 0; wr[m] = 1'($urandom);
    addr[m] = AW'($urandom); wdata[m] = $urandom;
    strb[m] = 4'($urandom); prot[m] = 3'($urandom);
  endtask

  task automatic check_outputs(output bit [1:0] fin);
    bit eps, epen;
    bit [1:0] rdy;
    eps  = owner >= 0;
    epen = eps && in_acc;
    for (int m = 0; m < 2; m++) rdy[m] = (owner == m) && in_acc && PREADY && PCLKEN;
    fin = rdy;
    check_eq("PSEL", PSEL, eps);
    check_eq("PENABLE", PENABLE, epen);
    check_eq("PWRITE", PWRITE, eps ? wr[owner] : 1'b0);
    check_eq("PADDR", PADDR, eps ? addr[owner] : '0);
    check_eq("PWDATA", PWDATA, eps ? wdata[owner] : 32'h0);
    check_eq("PSTRB", PSTRB, eps ? strb[owner] : 4'h0);
    check_eq("PPROT", PPROT, eps ? prot[owner] : 3'h0);
    check_eq("M0_PREADY", M0_PREADY, rdy[0]);
    check_eq("M0_PSLVERR", M0_PSLVERR, rdy[0] & PSLVERR);
    check_eq("M0_PRDATA", M0_PRDATA, rdy[0] ? PRDATA : 32'h0);
    check_eq("M1_PREADY", M1_PREADY, rdy[1]);
    check_eq("M1_PSLVERR", M1_PSLVERR, rdy[1] & PSLVERR);
    check_eq("M1_PRDATA", M1_PRDATA, rdy[1] ? PRDATA : 32'h0);
    check_eq("APBACTIVE", APBACTIVE, M0_PSEL | M1_PSEL | eps);
  endtask

  // mode 0: random enable/ready; 1: enable on, random ready; 2: enable toggles; 3: all on
  task automatic cycle(input int mode, input bit [1:0] allow, input int prob);
    bit [1:0] fin;
    @(negedge HCLK);
    check_outputs(fin);
    @(posedge HCLK);
    model_step();
    #1;
    for (int m = 0; m < 2; m++) begin
      if (act[m] && fin[m]) act[m] = 1'b0;
      else if (act[m]) age[m]++;
      if (!act[m] && allow[m] && ($urandom_range(0, 99) < prob)) new_txn(m);
    end
    drive_masters();
    PRDATA  = $urandom;
    PSLVERR = ($urandom_range(0, 3) == 0);
    case (mode)
      0: begin PCLKEN = ($urandom_range(0, 3) != 0); PREADY = ($urandom_range(0, 9) < 6); end
      1: begin PCLKEN = 1'b1; PREADY = ($urandom_range(0, 2) == 0); end
      2: begin PCLKEN = ~PCLKEN; PREADY = 1'b1; end
      default: begin PCLKEN = 1'b1; PREADY = 1'b1; end
    endcase
  endtask

  task automatic reset_in_access();
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cycle(1, 2'b11, 70);
      hit = in_acc;
    end
    check_eq("reach_access", hit, 1'b1);
    HRESET = 1'b1;
    model_reset();
    act[0] = 1'b0; act[1] = 1'b0;
    drive_masters();
    #1;
    check_eq("rst_PSEL", PSEL, 1'b0);
    check_eq("rst_PENABLE", PENABLE, 1'b0);
    for (int i = 0; i < 2; i++) cycle(3, 2'b00, 0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    new_txn(0); new_txn(1);
    drive_masters();
    PCLKEN = 1'b1; PREADY = 1'b1;
    for (int i = 0; i < 12; i++) cycle(3, 2'b00, 0);
  endtask

  initial begin
    act[0] = 1'b0; act[1] = 1'b0; age[0] = 0; age[1] = 0;
    wr[0] = 1'b0; wr[1] = 1'b0; addr[0] = '0; addr[1] = '0;
    wdata[0] = 32'h0; wdata[1] = 32'h0; strb[0] = 4'h0; strb[1] = 4'h0;
    prot[0] = 3'h0; prot[1] = 3'h0;
    HRESET = 1'b1; PCLKEN = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0;
    drive_masters();
    for (int i = 0; i < 2; i++) cycle(3, 2'b00, 0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    // Directed single M0 write: address 0x0040, data 0xA5A5_1234, full strobes.
    act[0] = 1'b1; age[0] = 0; wr[0] = 1'b1; addr[0] = 16'h0040;
    wdata[0] = 32'hA5A5_1234; strb[0] = 4'hF; prot[0] = 3'b000;
    drive_masters();
    for (int i = 0; i < 6; i++) cycle(3, 2'b00, 0);
    // Single-master traffic with slave wait states, then enable toggling.
    for (int i = 0; i < 80; i++) cycle(1, 2'b10, 40);
    for (int i = 0; i < 80; i++) cycle(2, 2'b01, 50);
    // Simultaneous requests from both masters.
    new_txn(0); new_txn(1);
    drive_masters();
    for (int i = 0; i < 40; i++) cycle(3, 2'b11, 100);
    for (int i = 0; i < 1500; i++) cycle(0, 2'b11, 45);
    reset_in_access();
    for (int i = 0; i < 400; i++) cycle(0, 2'b11, 60);
    reset_in_access();
    for (int i = 0; i < 300; i++) cycle(2, 2'b11, 60);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
